spine_port_arbiter: RTL and testbench

SPINE_PORT_ARBITER -- requirements
Module: spine_port_arbiter

---
 rtl/spine_pkg.sv | 23 ++
 rtl/rr_pick.sv | 48 ++++
 rtl/spine_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_spine_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spine_pkg.sv
// spine_pkg
//   Shared definitions for the spine output-port arbiter:
//   - arbiter FSM state enum (IDLE, BUSY)
//   - default requester count, grant index width, burst limit
//   - saturating 16-bit increment helper used by the optional
//     per-requester grant statistics (SPINE_ARB_STATS_EN)
package spine_pkg;

   localparam int unsigned SPINE_NUM_REQ   = 11;
   localparam int unsigned SPINE_IDX_W     = 4;
   localparam int unsigned SPINE_MAX_BURST = 8;
   localparam int unsigned SPINE_STAT_W    = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   function automatic logic [SPINE_STAT_W-1:0] sat_inc16(input logic [SPINE_STAT_W-1:0] v);
      return (v == '1) ? v : v + SPINE_STAT_W'(1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
//   Combinational rotating-priority search: returns the first set bit of
//   req at or after rr_ptr, wrapping modulo NUM_REQ.
//   Ports:
//     req    in  NUM_REQ  request vector
//     rr_ptr in  IDX_W    search start position (always < NUM_REQ)
//     found  out 1        any request bit set
//     idx    out IDX_W    index of the selected requester, 0 when none
module rr_pick
   import spine_pkg::*;
#(
   parameter int unsigned NUM_REQ = SPINE_NUM_REQ,
   parameter int unsigned IDX_W   = SPINE_IDX_W
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   localparam int unsigned DW = 2 * NUM_REQ;

   logic [DW-1:0] rot;
   logic [DW-1:0] sh;
   int unsigned   pos;

   // Doubling req and shifting by rr_ptr puts the wrapped search order at
   // bits [NUM_REQ-1:0], so a plain lowest-first scan does the rotation.
   always_comb begin
      rot   = {req, req} >> rr_ptr;
      sh    = '0;
      pos   = 0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         sh = rot >> i;
         if (!found && sh[0]) begin
            found = 1'b1;
            pos   = 32'(rr_ptr) + i;
            if (pos >= NUM_REQ) begin
               pos = pos - NUM_REQ;
            end
            idx = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/spine_port_arbiter.sv
// spine_port_arbiter
//   Round-robin arbiter granting one spine output port to one of NUM_REQ
//   input ports. A grant is held for a packet (until last), for at most
//   MAX_BURST accepted flits, or until the owner drops its request.
//   Ports:
//     clk          in  1        rising-edge clock
//     reset        in  1        asynchronous, active-low reset
//     req          in  NUM_REQ  per-requester flit valid
//     last         in  NUM_REQ  per-requester end-of-packet, qualified by req
//     out_full     in  1        output FIFO full; stalls the granted flow
//     grant        out NUM_REQ  registered one-hot grant
//     grant_valid  out 1        a grant is held
//     grant_idx    out IDX_W    granted requester index, 0 when idle
//     xfer         out 1        flit accepted this cycle (combinational)
//   Optional (macro SPINE_ARB_STATS_EN):
//     stat_sel     in  IDX_W    statistics counter select
//     stat_cnt     out 16       completed-grant count of stat_sel, 0 if out of range
module spine_port_arbiter
   import spine_pkg::*;
#(
   parameter int unsigned NUM_REQ   = SPINE_NUM_REQ,
   parameter int unsigned IDX_W     = SPINE_IDX_W,
   parameter int unsigned MAX_BURST = SPINE_MAX_BURST
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] last,
   input  logic               out_full,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               xfer
`ifdef SPINE_ARB_STATS_EN
   ,
   input  logic [IDX_W-1:0]   stat_sel,
   output logic [15:0]        stat_cnt
`endif
);

   localparam int unsigned CNT_W = ($clog2(MAX_BURST) > 4) ? $clog2(MAX_BURST) : 4;

   arb_state_e         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [IDX_W-1:0]   ptr_q,   ptr_d;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic               busy;
   logic               req_sel;
   logic               last_sel;
   logic               burst_end;
   logic               finish;
   logic               abandon;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (req),
      .rr_ptr (ptr_q),
      .found  (pick_found),
      .idx    (pick_idx)
   );

   // grant_q is one-hot (or zero), so masking with it selects the owner's
   // req/last bits without an index into the request vectors.
   assign busy      = (state_q == BUSY);
   assign req_sel   = |(req & grant_q);
   assign last_sel  = |(last & grant_q);
   assign xfer      = busy & req_sel & ~out_full;
   assign burst_end = last_sel | (cnt_q == CNT_W'(MAX_BURST - 1));
   assign finish    = xfer & burst_end;
   assign abandon   = busy & ~req_sel;

   assign grant       = grant_q;
   assign grant_valid = busy;
   assign grant_idx   = idx_q;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = BUSY;
               grant_d = NUM_REQ'(1) << pick_idx;
               idx_d   = pick_idx;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (finish || abandon) begin
               state_d = IDLE;
               grant_d = '0;
               idx_d   = '0;
               cnt_d   = '0;
               ptr_d   = (32'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + IDX_W'(1);
            end else if (xfer) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef SPINE_ARB_STATS_EN
   logic [15:0] stat_q [NUM_REQ];

   // Only completed grants (last or burst limit) are counted; abandons are not.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            stat_q[i] <= '0;
         end
      end else if (finish) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (32'(idx_q) == i) begin
               stat_q[i] <= sat_inc16(stat_q[i]);
            end
         end
      end
   end

   always_comb begin
      stat_cnt = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (32'(stat_sel) == i) begin
            stat_cnt = stat_q[i];
         end
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_spine_port_arbiter.sv
module tb_spine_port_arbiter;

   localparam int N  = 11;
   localparam int IW = 4;
   localparam int MB = 8;

   typedef struct {
      logic [N-1:0]  req;
      logic [N-1:0]  last;
      logic          full;
      logic          ev;
      logic [IW-1:0] eidx;
      logic          ex;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req;
   logic [N-1:0]  last;
   logic          out_full;
   logic [N-1:0]  grant;
   logic          grant_valid;
   logic [IW-1:0] grant_idx;
   logic          xfer;
`ifdef SPINE_ARB_STATS_EN
   logic [IW-1:0] stat_sel;
   logic [15:0]   stat_cnt;
`endif

   spine_port_arbiter #(
      .NUM_REQ   (N),
      .IDX_W     (IW),
      .MAX_BURST (MB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .last        (last),
      .out_full    (out_full),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx),
      .xfer        (xfer)
`ifdef SPINE_ARB_STATS_EN
      ,
      .stat_sel    (stat_sel),
      .stat_cnt    (stat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: owner index, flits accepted in this grant, next
   // search start, and per-requester completed-grant counts.
   bit m_busy;
   int m_idx;
   int m_cnt;
   int m_ptr;
   int m_stat [N];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0;
      m_idx  = 0;
      m_cnt  = 0;
      m_ptr  = 0;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
   endtask

   function automatic int model_pick(input logic [N-1:0] r);
      for (int k = 0; k < N; k++) begin
         if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic f);
      int p;
      if (!m_busy) begin
         p = model_pick(r);
         if (p >= 0) begin
            m_busy = 1;
            m_idx  = p;
            m_cnt  = 0;
         end
      end else if (!r[m_idx]) begin
         m_busy = 0;
         m_ptr  = (m_idx + 1) % N;
      end else if (!f) begin
         if (l[m_idx] || m_cnt == MB - 1) begin
            if (m_stat[m_idx] < 65535) m_stat[m_idx]++;
            m_busy = 0;
            m_ptr  = (m_idx + 1) % N;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] l, input logic f);
      req      = r;
      last     = l;
      out_full = f;
`ifdef SPINE_ARB_STATS_EN
      stat_sel = IW'($urandom_range(0, 15));
`endif
      #2;
   endtask

   // Compare all outputs against the model, advance the model, then the clock.
   task automatic tick();
      logic [N-1:0] eg;
      eg = m_busy ? (N'(1) << m_idx) : '0;
      chk("grant", 32'(grant), 32'(eg));
      chk("grant_valid", 32'(grant_valid), 32'(m_busy));
      chk("grant_idx", 32'(grant_idx), m_busy ? m_idx : 0);
      chk("xfer", 32'(xfer), 32'(m_busy && req[m_idx] && !out_full));
`ifdef SPINE_ARB_STATS_EN
      chk("stat_cnt", 32'(stat_cnt), (int'(stat_sel) < N) ? m_stat[stat_sel] : 0);
`endif
      model_step(req, last, out_full);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_valid", 32'(grant_valid), 0);
      chk("rst_idx", 32'(grant_idx), 0);
      chk("rst_xfer", 32'(xfer), 0);
      req      = '0;
      last     = '0;
      out_full = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   localparam logic [N-1:0] ALL = {N{1'b1}};

   vec_t tbl [8];

   initial begin
      logic [N-1:0] r, l;
      int           nt;

      tbl[0] = '{req: N'(1) << 3, last: '0,          full: 0, ev: 0, eidx: 0, ex: 0};
      tbl[1] = '{req: N'(1) << 3, last: '0,          full: 0, ev: 1, eidx: 3, ex: 1};
      tbl[2] = '{req: N'(1) << 3, last: '0,          full: 0, ev: 1, eidx: 3, ex: 1};
      tbl[3] = '{req: N'(1) << 3, last: N'(1) << 3,  full: 0, ev: 1, eidx: 3, ex: 1};
      tbl[4] = '{req: '0,         last: '0,          full: 0, ev: 0, eidx: 0, ex: 0};
      tbl[5] = '{req: (N'(1) << 3) | (N'(1) << 5), last: '0, full: 0, ev: 0, eidx: 0, ex: 0};
      tbl[6] = '{req: N'(1) << 5, last: N'(1) << 5,  full: 0, ev: 1, eidx: 5, ex: 1};
      tbl[7] = '{req: '0,         last: '0,          full: 0, ev: 0, eidx: 0, ex: 0};

      reset    = 1'b1;
      req      = '0;
      last     = '0;
      out_full = 1'b0;
`ifdef SPINE_ARB_STATS_EN
      stat_sel = '0;
`endif
      #1;
      do_reset();

      // Single requester 3, then pointer at 4 makes 5 win over 3.
      for (int i = 0; i < 8; i++) begin
         set_in(tbl[i].req, tbl[i].last, tbl[i].full);
         chk("tbl_valid", 32'(grant_valid), 32'(tbl[i].ev));
         chk("tbl_idx", 32'(grant_idx), 32'(tbl[i].eidx));
         chk("tbl_xfer", 32'(xfer), 32'(tbl[i].ex));
         chk("tbl_grant", 32'(grant), tbl[i].ev ? (32'(1) << tbl[i].eidx) : 0);
         tick();
      end

      // Fairness: all requesting, single-flit packets.
      do_reset();
      for (int g = 0; g < 12; g++) begin
         set_in(ALL, ALL, 1'b0);
         chk("fair_idle", 32'(grant_valid), 0);
         tick();
         set_in(ALL, ALL, 1'b0);
         chk("fair_idx", 32'(grant_idx), g % N);
         chk("fair_xfer", 32'(xfer), 1);
         tick();
      end

      // Burst limit: 5 never sends last; 6 is next.
      do_reset();
      r = (N'(1) << 5) | (N'(1) << 6);
      set_in(r, '0, 1'b0);
      tick();
      for (int k = 0; k < MB; k++) begin
         set_in(r, '0, 1'b0);
         chk("tmo_idx", 32'(grant_idx), 5);
         chk("tmo_xfer", 32'(xfer), 1);
         tick();
      end
      set_in(r, '0, 1'b0);
      chk("tmo_release", 32'(grant_valid), 0);
      tick();
      set_in(r, '0, 1'b0);
      chk("tmo_next", 32'(grant_idx), 6);
      tick();
      set_in('0, '0, 1'b0);
      tick();

      // Backpressure: 2 flits, 5 stalled cycles, then 6 more reach the limit.
      do_reset();
      r = N'(1) << 2;
      set_in(r, '0, 1'b0);
      tick();
      for (int k = 0; k < 2; k++) begin
         set_in(r, '0, 1'b0);
         chk("bp_pre_xfer", 32'(xfer), 1);
         tick();
      end
      for (int k = 0; k < 5; k++) begin
         set_in(r, '0, 1'b1);
         chk("bp_stall_xfer", 32'(xfer), 0);
         chk("bp_stall_idx", 32'(grant_idx), 2);
         chk("bp_stall_valid", 32'(grant_valid), 1);
         tick();
      end
      for (int k = 0; k < MB - 2; k++) begin
         set_in(r, '0, 1'b0);
         chk("bp_post_xfer", 32'(xfer), 1);
         tick();
      end
      set_in(r, '0, 1'b0);
      chk("bp_release", 32'(grant_valid), 0);
      tick();
      set_in('0, '0, 1'b0);
      tick();
      set_in('0, '0, 1'b0);
      tick();

      // Abandon by 7, pointer moves to 8; reset mid-burst restarts at 0.
      do_reset();
      r = N'(1) << 7;
      set_in(r, '0, 1'b0);
      tick();
      set_in(r, '0, 1'b0);
      chk("ab_xfer", 32'(xfer), 1);
      tick();
      set_in('0, '0, 1'b0);
      chk("ab_drop_xfer", 32'(xfer), 0);
      tick();
      r = (N'(1) << 7) | (N'(1) << 8);
      set_in(r, '0, 1'b0);
      chk("ab_idle", 32'(grant_valid), 0);
      tick();
      r = (N'(1) << 4) | (N'(1) << 8);
      set_in(r, '0, 1'b0);
      chk("ab_next", 32'(grant_idx), 8);
      tick();
      do_reset();
      set_in(r, '0, 1'b0);
      tick();
      set_in(r, '0, 1'b0);
      chk("rst_restart", 32'(grant_idx), 4);
      tick();
      set_in('0, '0, 1'b0);
      tick();

`ifdef SPINE_ARB_STATS_EN
      do_reset();
      r = N'(1) << 1;
      for (int k = 0; k < 3; k++) begin
         set_in(r, r, 1'b0);
         tick();
         set_in(r, r, 1'b0);
         chk("st_idx", 32'(grant_idx), 1);
         tick();
      end
      set_in(r, '0, 1'b0);
      tick();
      set_in(r, '0, 1'b0);
      tick();
      set_in('0, '0, 1'b0);
      tick();
      set_in('0, '0, 1'b0);
      stat_sel = IW'(1);
      #1;
      chk("st_cnt1", 32'(stat_cnt), 3);
      stat_sel = IW'(12);
      #1;
      chk("st_cnt12", 32'(stat_cnt), 0);
      tick();
`endif

      // Randomized traffic with sticky requests against the model.
      do_reset();
      r  = '0;
      nt = 3000;
      for (int c = 0; c < nt; c++) begin
         r = r ^ N'($urandom & $urandom & $urandom);
         l = N'($urandom & $urandom);
         set_in(r, l, ($urandom_range(0, 4) == 0));
         tick();
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
